isp_frame_ctrl: RTL and testbench
=================================

// Module: isp_frame_ctrl
// PURPOSE
//  Frame sequencer in front of the processing pipeline (demosaic -> filter -> rgb2ycc).
//  Admits exactly one frame of pixels per run and collects each stage's done pulse.
//  Then issues a one-cycle flush/reset to all stages and either idles or re-arms for the next frame.
//  Replaces the ad-hoc "reset | oDone" stage-restart wiring with one sequenced point.
// PARAMETERS
//  width       320             pixels per line
//  height      240             lines per frame
//  frameSize   width*height    pixels admitted per frame
//  NUM_STAGES  3               stage count (bit 0 demosaic, 1 filter, 2 rgb2ycc)
//  TIMEOUT     4096            max DRAIN cycles waiting for stage dones
// PORTS
//  clk          in   1           clock
//  reset        in   1           async, active-high
//  iStart       in   1           begin run; sampled in IDLE only
//  iAbort       in   1           cancel current run
//  iContinuous  in   1           re-arm automatically after each frame
//  iStageMask   in   NUM_STAGES  1 = wait for this stage's done; 0 = treat as done
//  iPixValid    in   1           source pixel valid (data bypasses this block)
//  iStageDone   in   NUM_STAGES  per-stage frame-done pulses
//  oPixValid    out  1           gated valid to pipeline
//  oStageReset  out  NUM_STAGES  per-stage flush pulse (top ORs with reset)
//  oBusy        out  1           state != IDLE
//  oFrameDone   out  1           1-cycle pulse per completed frame
//  oTimeout     out  1           sticky: last frame ended by timeout
//  oPixCnt      out  17          pixels admitted this frame
//  oDropCnt     out  16          pixels dropped while not in FEED (saturating)
//  oFrameCnt    out  16          completed frames (wraps)
// BEHAVIOUR
//  Reset: state=IDLE, all counters/flags 0, every output 0 immediately (no clock edge needed).
//  States: IDLE, FLUSH, FEED, DRAIN. go flag selects FLUSH exit.
//  IDLE: iStart -> FLUSH with go=1. iStart in any other state is ignored.
//  FLUSH (exactly 1 cycle):
//    oStageReset = all ones; done flags, oPixCnt and DRAIN timer cleared.
//    Exit -> FEED if go, else -> IDLE.
//  FEED:
//    oPixValid = iPixValid combinationally (zero latency).
//    Each admitted pixel increments oPixCnt.
//    Admitted pixel with oPixCnt==frameSize-1 is forwarded; next state DRAIN.
//  DRAIN: oPixValid=0; timer counts up each cycle.
//    Exit when (flags | ~iStageMask) is all ones, or timer==TIMEOUT-1.
//    Exit -> FLUSH with go=iContinuous; oFrameDone=1 in that FLUSH cycle;
//    oFrameCnt++; oTimeout=1 if the exit was the timeout, else 0.
//  Done flags: flag[i] set by iStageDone[i] in FEED or DRAIN, sticky until FLUSH.
//    A done arriving in a FLUSH cycle is lost.
//  Drops: iPixValid outside FEED -> oDropCnt++ (saturates 16'hFFFF, cleared by iStart).
//  iStart also clears oTimeout.
//  iAbort: highest priority, any non-IDLE state -> FLUSH with go=0.
//    No oFrameDone; oFrameCnt unchanged; ignored in IDLE.
//  Simultaneous DRAIN exit and iAbort: abort wins, no oFrameDone.
//  oStageReset and oFrameDone are decoded from the registered state (glitch-free).
//  oBusy=1 in FLUSH/FEED/DRAIN.
//  Mask all zero: DRAIN lasts exactly 1 cycle.
// TESTING (width=4, height=2, TIMEOUT=16, mask=3'b111)
//  1. Start, then 9 back-to-back iPixValid ->
//     FLUSH at T+1; oPixValid for pixels 1-8 only; oDropCnt=1.
//     Dones at +2/+4/+6 -> oFrameDone and oStageReset=3'b111 for one cycle;
//     oFrameCnt=1; IDLE.
//  2. iContinuous=1, two frames with valid gaps and all dones ->
//     two oFrameDone pulses; oFrameCnt=2; oPixCnt returns to 0 between frames;
//     oBusy stays 1 throughout.
//  3. Only dones 0 and 1 arrive ->
//     16 cycles into DRAIN, oFrameDone=1 and oTimeout=1;
//     oTimeout held until next iStart.
//  4. iAbort after 4 admitted pixels ->
//     1-cycle oStageReset, then IDLE; oFrameDone never asserted; oFrameCnt unchanged.
//  5. reset asserted mid-DRAIN between clock edges ->
//     oBusy, oPixCnt, oFrameCnt read 0 before the next edge.
//  6. iStageMask=3'b001, only iStageDone[0] pulses -> oFrameDone, oTimeout=0.
//     Done pulse coincident with last pixel in FEED is still counted.

Source files
------------

// File: rtl/isp_frame_ctrl_if.sv
// Pixel-valid and per-stage done/reset wiring between the frame sequencer and the pipeline.
// master = sequencer side, slave = source/pipeline side.
interface isp_frame_ctrl_if #(
  parameter int NUM_STAGES = 3
);
  logic                  iPixValid;
  logic                  oPixValid;
  logic [NUM_STAGES-1:0] iStageDone;
  logic [NUM_STAGES-1:0] oStageReset;

  modport master (
    input  iPixValid,
    input  iStageDone,
    output oPixValid,
    output oStageReset
  );

  modport slave (
    output iPixValid,
    output iStageDone,
    input  oPixValid,
    input  oStageReset
  );
endinterface

// File: rtl/isp_frame_ctrl.sv
// Frame sequencer: admits one frame of pixels, collects stage dones, then issues a
// single-cycle flush to every stage before idling or re-arming.
module isp_frame_ctrl #(
  parameter int width      = 320,
  parameter int height     = 240,
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iStart,
  input  logic                  iAbort,
  input  logic                  iContinuous,
  input  logic [NUM_STAGES-1:0] iStageMask,
  isp_frame_ctrl_if.master      bus,
  output logic                  oBusy,
  output logic                  oFrameDone,
  output logic                  oTimeout,
  output logic [16:0]           oPixCnt,
  output logic [15:0]           oDropCnt,
  output logic [15:0]           oFrameCnt
);

  localparam int frameSize = width * height;
  localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, FEED, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  go_q, go_d;
  logic                  fin_q, fin_d;
  logic [NUM_STAGES-1:0] flags_q, flags_d;
  logic [16:0]           pix_cnt_q, pix_cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  pix_fwd;
  logic                  all_done;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    go_d        = go_q;
    fin_d       = fin_q;
    flags_d     = flags_q;
    pix_cnt_d   = pix_cnt_q;
    timer_d     = timer_q;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    timeout_d   = timeout_q;
    pix_fwd     = 1'b0;
    all_done    = &(flags_q | ~iStageMask);

    if (bus.iPixValid && (state_q != FEED) && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d    = FLUSH;
          go_d       = 1'b1;
          fin_d      = 1'b0;
          drop_cnt_d = '0;
          timeout_d  = 1'b0;
        end
      end
      FLUSH: begin
        flags_d   = '0;
        pix_cnt_d = '0;
        timer_d   = '0;
        fin_d     = 1'b0;
        state_d   = go_q ? FEED : IDLE;
      end
      FEED: begin
        flags_d = flags_q | bus.iStageDone;
        if (bus.iPixValid) begin
          pix_fwd   = 1'b1;
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == 17'(frameSize - 1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        flags_d = flags_q | bus.iStageDone;
        timer_d = timer_q + 1'b1;
        // Dones take precedence: a frame that completes on the last timer tick is not a timeout.
        if (all_done || (timer_q == TW'(TIMEOUT - 1))) begin
          state_d     = FLUSH;
          go_d        = iContinuous;
          fin_d       = 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
          timeout_d   = ~all_done;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides any completion decided above in the same cycle.
    if (iAbort && (state_q != IDLE)) begin
      state_d     = FLUSH;
      go_d        = 1'b0;
      fin_d       = 1'b0;
      frame_cnt_d = frame_cnt_q;
      timeout_d   = timeout_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      go_q        <= 1'b0;
      fin_q       <= 1'b0;
      flags_q     <= '0;
      pix_cnt_q   <= '0;
      timer_q     <= '0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      fin_q       <= fin_d;
      flags_q     <= flags_d;
      pix_cnt_q   <= pix_cnt_d;
      timer_q     <= timer_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Flush and frame-done come straight off registered state so they never glitch.
  assign bus.oPixValid   = pix_fwd;
  assign bus.oStageReset = {NUM_STAGES{state_q == FLUSH}};
  assign oFrameDone      = (state_q == FLUSH) && fin_q;
  assign oBusy           = (state_q != IDLE);
  assign oTimeout        = timeout_q;
  assign oPixCnt         = pix_cnt_q;
  assign oDropCnt        = drop_cnt_q;
  assign oFrameCnt       = frame_cnt_q;

endmodule

// File: tb/tb_isp_frame_ctrl.sv
// Directed bench for isp_frame_ctrl (4x2 frame, TIMEOUT 16) with scoreboards for
// forwarded pixels and frame-done events.
module tb_isp_frame_ctrl;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          iStart = 1'b0;
  logic          iAbort = 1'b0;
  logic          iContinuous = 1'b0;
  logic [NS-1:0] iStageMask = '1;
  logic          oBusy, oFrameDone, oTimeout;
  logic [16:0]   oPixCnt;
  logic [15:0]   oDropCnt, oFrameCnt;

  isp_frame_ctrl_if #(.NUM_STAGES(NS)) bus();

  isp_frame_ctrl #(
    .width(4), .height(2), .NUM_STAGES(NS), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .iAbort(iAbort),
    .iContinuous(iContinuous), .iStageMask(iStageMask), .bus(bus),
    .oBusy(oBusy), .oFrameDone(oFrameDone), .oTimeout(oTimeout),
    .oPixCnt(oPixCnt), .oDropCnt(oDropCnt), .oFrameCnt(oFrameCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cnt;
    logic        tmo;
  } fd_t;

  fd_t  fd_q[$];
  logic pix_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input int gap);
    int sent = 0;
    int k = 0;
    logic v;
    while (sent < n) begin
      chk("busy_feed", 32'(oBusy), 32'd1);
      v = (gap == 0) || ((k % gap) != (gap - 1));
      bus.iPixValid = v;
      if (v) begin
        pix_q.push_back(1'b1);
        sent++;
      end
      tick();
      k++;
    end
    bus.iPixValid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while ((oFrameDone !== 1'b1) && (n < 64)) begin
      tick();
      n++;
    end
  endtask

  task automatic push_fd(input logic tmo);
    fd_t e;
    exp_frames++;
    e.cnt = 16'(exp_frames);
    e.tmo = tmo;
    fd_q.push_back(e);
  endtask

  // Scoreboard side: compare DUT outputs mid-cycle against queued expectations.
  always @(negedge clk) begin
    fd_t  e;
    logic pe;
    if (!reset) begin
      if (bus.iPixValid) begin
        pe = (pix_q.size() > 0) ? pix_q.pop_front() : 1'b0;
        chk("pix_fwd", 32'(bus.oPixValid), 32'(pe));
      end else begin
        chk("pix_idle", 32'(bus.oPixValid), 32'd0);
      end
      if (oFrameDone) begin
        if (fd_q.size() == 0) begin
          chk("fd_unexpected", 32'(oFrameDone), 32'd0);
        end else begin
          e = fd_q.pop_front();
          chk("fd_cnt", 32'(oFrameCnt), 32'(e.cnt));
          chk("fd_tmo", 32'(oTimeout), 32'(e.tmo));
          chk("fd_rst", 32'(bus.oStageReset), 32'({NS{1'b1}}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.iPixValid  = 1'b0;
    bus.iStageDone = '0;

    // Asynchronous reset, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_pixcnt", 32'(oPixCnt), 32'd0);
    chk("rst_drop", 32'(oDropCnt), 32'd0);
    chk("rst_frames", 32'(oFrameCnt), 32'd0);
    chk("rst_tmo", 32'(oTimeout), 32'd0);
    chk("rst_fd", 32'(oFrameDone), 32'd0);
    chk("rst_srst", 32'(bus.oStageReset), 32'd0);
    chk("rst_pixv", 32'(bus.oPixValid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 1: single frame, ninth pixel dropped, dones spread through DRAIN.
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("t1_flush_srst", 32'(bus.oStageReset), 32'd7);
    chk("t1_flush_busy", 32'(oBusy), 32'd1);
    chk("t1_flush_fd", 32'(oFrameDone), 32'd0);
    tick();
    for (int k = 0; k < 9; k++) begin
      bus.iPixValid = 1'b1;
      pix_q.push_back(k < 8);
      tick();
    end
    bus.iPixValid = 1'b0;
    chk("t1_pixcnt", 32'(oPixCnt), 32'd8);
    chk("t1_drop", 32'(oDropCnt), 32'd1);
    bus.iStageDone = 3'b001; tick();
    bus.iStageDone = 3'b000; tick();
    bus.iStageDone = 3'b010; tick();
    bus.iStageDone = 3'b000; tick();
    push_fd(1'b0);
    bus.iStageDone = 3'b100; tick();
    bus.iStageDone = 3'b000;
    chk("t1_not_yet", 32'(oFrameDone), 32'd0);
    wait_done(n);
    chk("t1_latency", 32'(n), 32'd1);
    chk("t1_fd_srst", 32'(bus.oStageReset), 32'd7);
    chk("t1_frames", 32'(oFrameCnt), 32'(exp_frames));
    tick();
    chk("t1_idle_busy", 32'(oBusy), 32'd0);
    chk("t1_idle_srst", 32'(bus.oStageReset), 32'd0);

    // 2: continuous mode, two frames with valid gaps.
    iContinuous = 1'b1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("t2_drop_clr", 32'(oDropCnt), 32'd0);
    chk("t2_busy_flush", 32'(oBusy), 32'd1);
    tick();
    feed(8, 3);
    push_fd(1'b0);
    bus.iStageDone = 3'b111; tick();
    bus.iStageDone = 3'b000;
    wait_done(n);
    chk("t2_lat_a", 32'(n), 32'd1);
    chk("t2_busy_fd", 32'(oBusy), 32'd1);
    tick();
    chk("t2_rearm_busy", 32'(oBusy), 32'd1);
    chk("t2_rearm_pixcnt", 32'(oPixCnt), 32'd0);
    feed(8, 2);
    iContinuous = 1'b0;
    push_fd(1'b0);
    bus.iStageDone = 3'b111; tick();
    bus.iStageDone = 3'b000;
    wait_done(n);
    chk("t2_lat_b", 32'(n), 32'd1);
    chk("t2_frames", 32'(oFrameCnt), 32'(exp_frames));
    tick();
    chk("t2_idle", 32'(oBusy), 32'd0);

    // 3: stage 2 never finishes, timeout after 16 DRAIN cycles.
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    feed(8, 0);
    bus.iStageDone = 3'b011; tick();
    bus.iStageDone = 3'b000;
    push_fd(1'b1);
    wait_done(n);
    chk("t3_latency", 32'(n), 32'd15);
    chk("t3_tmo", 32'(oTimeout), 32'd1);
    tick(); tick(); tick();
    chk("t3_tmo_held", 32'(oTimeout), 32'd1);
    chk("t3_idle", 32'(oBusy), 32'd0);

    // 4: abort mid-frame, then drops while idle.
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("t4_tmo_clr", 32'(oTimeout), 32'd0);
    tick();
    feed(4, 0);
    chk("t4_pixcnt", 32'(oPixCnt), 32'd4);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    chk("t4_abort_srst", 32'(bus.oStageReset), 32'd7);
    chk("t4_abort_fd", 32'(oFrameDone), 32'd0);
    chk("t4_abort_frames", 32'(oFrameCnt), 32'(exp_frames));
    tick();
    chk("t4_idle_busy", 32'(oBusy), 32'd0);
    chk("t4_idle_srst", 32'(bus.oStageReset), 32'd0);
    for (int k = 0; k < 2; k++) begin
      bus.iPixValid = 1'b1;
      pix_q.push_back(1'b0);
      tick();
    end
    bus.iPixValid = 1'b0;
    chk("t4_idle_drop", 32'(oDropCnt), 32'd2);

    // 6: only stage 0 enabled; its done coincides with the last pixel.
    iStageMask = 3'b001;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("t6_drop_clr", 32'(oDropCnt), 32'd0);
    tick();
    feed(7, 0);
    bus.iPixValid  = 1'b1;
    bus.iStageDone = 3'b001;
    pix_q.push_back(1'b1);
    push_fd(1'b0);
    tick();
    bus.iPixValid  = 1'b0;
    bus.iStageDone = 3'b000;
    wait_done(n);
    chk("t6_latency", 32'(n), 32'd1);
    chk("t6_tmo", 32'(oTimeout), 32'd0);
    tick();

    // 5: reset asserted between edges while in DRAIN.
    iStageMask = '1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    feed(8, 0);
    tick();
    tick();
    chk("t5_pre_pixcnt", 32'(oPixCnt), 32'd8);
    chk("t5_pre_frames", 32'(oFrameCnt), 32'(exp_frames));
    chk("t5_pre_busy", 32'(oBusy), 32'd1);
    #2 reset = 1'b1;
    #1;
    exp_frames = 0;
    chk("t5_busy", 32'(oBusy), 32'd0);
    chk("t5_pixcnt", 32'(oPixCnt), 32'd0);
    chk("t5_frames", 32'(oFrameCnt), 32'(exp_frames));
    chk("t5_srst", 32'(bus.oStageReset), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    chk("end_busy", 32'(oBusy), 32'd0);
    chk("end_fd_pending", 32'(fd_q.size()), 32'd0);
    chk("end_pix_pending", 32'(pix_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
